// File: rtl/VX_tb_common_pkg.sv
// Shared widths and the fetch-request payload used by the warp issue path.
package VX_tb_common_pkg;

  localparam int unsigned NUM_WARPS   = 4;
  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned PC_BITS     = 30;
  localparam int unsigned NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  // Request presented to fetch: warp id, its PC and its thread mask.
  typedef struct packed {
    logic [NW_WIDTH-1:0]    wid;
    logic [PC_BITS-1:0]     pc;
    logic [NUM_THREADS-1:0] tmask;
  } sched_req_t;

endpackage

// File: rtl/warp_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping modulo N.
module warp_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant_idx_c,
  output logic         any_valid_c
);

  int unsigned idx;

  // Scan from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin
    grant_idx_c = '0;
    any_valid_c = |req;
    idx         = 0;
    for (int unsigned i = N; i >= 1; i--) begin
      idx = (32'(ptr) + i) % N;
      if (req[W'(idx)]) begin
        grant_idx_c = W'(idx);
      end
    end
  end

endmodule

// File: rtl/warp_issue_select.sv
// Round-robin warp issue select with one outstanding fetch request per warp.
// Optional perf counters are enabled by defining WARP_ISSUE_PERF_EN.
module warp_issue_select
  import VX_tb_common_pkg::sched_req_t;
#(
  parameter int unsigned NUM_WARPS   = VX_tb_common_pkg::NUM_WARPS,
  parameter int unsigned NUM_THREADS = VX_tb_common_pkg::NUM_THREADS,
  parameter int unsigned PC_BITS     = VX_tb_common_pkg::PC_BITS,
  parameter int unsigned NW_WIDTH    = VX_tb_common_pkg::NW_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_WARPS-1:0]             active_warps,
  input  logic [NUM_WARPS-1:0]             stalled_warps,
  input  logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  input  logic [NUM_WARPS*PC_BITS-1:0]     warp_pcs,
  output logic                             sched_valid,
  input  logic                             sched_ready,
  output logic [NW_WIDTH-1:0]              sched_wid,
  output logic [PC_BITS-1:0]               sched_pc,
  output logic [NUM_THREADS-1:0]           sched_tmask,
  input  logic                             release_valid,
  input  logic [NW_WIDTH-1:0]              release_wid,
  output logic [NUM_WARPS-1:0]             pending_warps,
  output logic                             err_release
`ifdef WARP_ISSUE_PERF_EN
  ,
  output logic [31:0]                      perf_issued,
  output logic [31:0]                      perf_idle,
  output logic [31:0]                      perf_backpressure
`endif
);

  logic [PC_BITS-1:0]     pc_arr_c    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_arr_c [NUM_WARPS];
  logic [NUM_WARPS-1:0]   eligible_c;
  logic [NW_WIDTH-1:0]    grant_c;
  logic                   any_elig_c;
  logic                   load_c;
  logic                   rel_hit_c;

  sched_req_t           req_q,     req_d;
  logic                 valid_q,   valid_d;
  logic [NUM_WARPS-1:0] pending_q, pending_d;
  logic                 err_q,     err_d;
  logic [NW_WIDTH-1:0]  rr_ptr_q,  rr_ptr_d;

  // Per-warp unpacking and eligibility from the registered pending bitmap.
  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    assign pc_arr_c[g]    = warp_pcs[g*PC_BITS +: PC_BITS];
    assign tmask_arr_c[g] = thread_masks[g*NUM_THREADS +: NUM_THREADS];
    assign eligible_c[g]  = active_warps[g] & ~stalled_warps[g] & ~pending_q[g]
                          & (|thread_masks[g*NUM_THREADS +: NUM_THREADS]);
  end

  warp_rr_pick #(
    .N (NUM_WARPS),
    .W (NW_WIDTH)
  ) u_pick (
    .req         (eligible_c),
    .ptr         (rr_ptr_q),
    .grant_idx_c (grant_c),
    .any_valid_c (any_elig_c)
  );

  assign load_c    = (~valid_q | sched_ready) & any_elig_c;
  // Out-of-range wids never hit; the pending lookup is masked by the range test.
  assign rel_hit_c = (32'(release_wid) < NUM_WARPS) && pending_q[release_wid];

  // Next-state: release bookkeeping, then output-register load or drain.
  always_comb begin
    req_d     = req_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    err_d     = err_q;
    rr_ptr_d  = rr_ptr_q;
    if (release_valid) begin
      if (rel_hit_c) begin
        pending_d[release_wid] = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    if (load_c) begin
      req_d.wid          = grant_c;
      req_d.pc           = pc_arr_c[grant_c];
      req_d.tmask        = tmask_arr_c[grant_c];
      valid_d            = 1'b1;
      pending_d[grant_c] = 1'b1;
      rr_ptr_d           = grant_c;
    end else if (sched_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; rr_ptr starts at the last warp so warp 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      valid_q   <= 1'b0;
      pending_q <= '0;
      err_q     <= 1'b0;
      rr_ptr_q  <= NW_WIDTH'(NUM_WARPS - 1);
    end else begin
      req_q     <= req_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign sched_valid   = valid_q;
  assign sched_wid     = req_q.wid;
  assign sched_pc      = req_q.pc;
  assign sched_tmask   = req_q.tmask;
  assign pending_warps = pending_q;
  assign err_release   = err_q;

`ifdef WARP_ISSUE_PERF_EN
  logic [31:0] issued_q, issued_d;
  logic [31:0] idle_q,   idle_d;
  logic [31:0] bp_q,     bp_d;

  // Saturating event counters.
  always_comb begin
    issued_d = issued_q;
    idle_d   = idle_q;
    bp_d     = bp_q;
    if (valid_q && sched_ready && (issued_q != '1)) begin
      issued_d = issued_q + 32'd1;
    end
    if (!valid_q && (active_warps != '0) && (idle_q != '1)) begin
      idle_d = idle_q + 32'd1;
    end
    if (valid_q && !sched_ready && (bp_q != '1)) begin
      bp_d = bp_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_q <= '0;
      idle_q   <= '0;
      bp_q     <= '0;
    end else begin
      issued_q <= issued_d;
      idle_q   <= idle_d;
      bp_q     <= bp_d;
    end
  end

  assign perf_issued       = issued_q;
  assign perf_idle         = idle_q;
  assign perf_backpressure = bp_q;
`endif

endmodule

// File: tb/tb_warp_issue_select.sv
// Scoreboard bench for warp_issue_select: behavioural model pushes expected requests,
// a negedge monitor pops and compares whenever the DUT presents a request.
module tb_warp_issue_select;

  localparam int NW  = 4;
  localparam int NT  = 4;
  localparam int PCB = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic [NW-1:0]     active_warps;
  logic [NW-1:0]     stalled_warps;
  logic [NW*NT-1:0]  thread_masks;
  logic [NW*PCB-1:0] warp_pcs;
  logic              sched_valid;
  logic              sched_ready;
  logic [1:0]        sched_wid;
  logic [PCB-1:0]    sched_pc;
  logic [NT-1:0]     sched_tmask;
  logic              release_valid;
  logic [1:0]        release_wid;
  logic [NW-1:0]     pending_warps;
  logic              err_release;
`ifdef WARP_ISSUE_PERF_EN
  logic [31:0]       perf_issued, perf_idle, perf_backpressure;
`endif

  warp_issue_select dut (
    .clk           (clk),
    .reset         (reset),
    .active_warps  (active_warps),
    .stalled_warps (stalled_warps),
    .thread_masks  (thread_masks),
    .warp_pcs      (warp_pcs),
    .sched_valid   (sched_valid),
    .sched_ready   (sched_ready),
    .sched_wid     (sched_wid),
    .sched_pc      (sched_pc),
    .sched_tmask   (sched_tmask),
    .release_valid (release_valid),
    .release_wid   (release_wid),
    .pending_warps (pending_warps),
    .err_release   (err_release)
`ifdef WARP_ISSUE_PERF_EN
    ,
    .perf_issued       (perf_issued),
    .perf_idle         (perf_idle),
    .perf_backpressure (perf_backpressure)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wid;
    bit [PCB-1:0] pc;
    bit [NT-1:0]  tmask;
  } req_exp_t;

  req_exp_t exp_q[$];
  int       fired[$];
  int       checks = 0;
  int       errors = 0;

  // Reference state: which warps are outstanding, who won last, whether a request is shown.
  bit [NW-1:0] m_pending;
  int          m_last;
  bit          m_showing;
  bit          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // First warp in the set after 'last', going round the ring.
  function automatic int next_in_ring(input bit [NW-1:0] cand, input int last);
    for (int off = 1; off <= NW; off++) begin
      int w;
      w = (last + off) % NW;
      if (cand[w]) return w;
    end
    return -1;
  endfunction

  // Behavioural model, advanced at every clock edge.
  always @(posedge clk) begin : model
    bit [NW-1:0] cand;
    bit [NW-1:0] nxt;
    int          w;
    req_exp_t    e;
    if (reset) begin
      m_pending = '0;
      m_last    = NW - 1;
      m_showing = 1'b0;
      m_err     = 1'b0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < NW; i++) begin
        cand[i] = active_warps[i] && !stalled_warps[i] && !m_pending[i]
                  && (thread_masks[i*NT +: NT] != '0);
      end
      nxt = m_pending;
      if (release_valid) begin
        if (int'(release_wid) < NW && m_pending[release_wid]) nxt[release_wid] = 1'b0;
        else m_err = 1'b1;
      end
      w = next_in_ring(cand, m_last);
      if ((!m_showing || sched_ready) && w >= 0) begin
        e.wid   = w;
        e.pc    = warp_pcs[w*PCB +: PCB];
        e.tmask = thread_masks[w*NT +: NT];
        exp_q.push_back(e);
        nxt[w]    = 1'b1;
        m_last    = w;
        m_showing = 1'b1;
      end else if (sched_ready) begin
        m_showing = 1'b0;
      end
      m_pending = nxt;
    end
  end

  // Monitor: compare what the DUT shows against the scoreboard head.
  always @(negedge clk) begin : monitor
    check("pending", 64'(pending_warps), 64'(m_pending));
    check("err_release", 64'(err_release), 64'(m_err));
    check("valid", 64'(sched_valid), 64'(exp_q.size() != 0));
    if (sched_valid && exp_q.size() != 0) begin
      check("wid", 64'(sched_wid), 64'(exp_q[0].wid));
      check("pc", 64'(sched_pc), 64'(exp_q[0].pc));
      check("tmask", 64'(sched_tmask), 64'(exp_q[0].tmask));
      if (sched_ready) begin
        fired.push_back(int'(sched_wid));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic new_pcs();
    for (int w = 0; w < NW; w++) warp_pcs[w*PCB +: PCB] = PCB'($urandom);
  endtask

  initial begin : stim
    logic [PCB-1:0] hold_pc;
    reset         = 1'b1;
    active_warps  = '0;
    stalled_warps = '0;
    thread_masks  = '1;
    warp_pcs      = '0;
    sched_ready   = 1'b0;
    release_valid = 1'b0;
    release_wid   = '0;
    new_pcs();
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_valid", 64'(sched_valid), 64'd0);
    check("rst_wid", 64'(sched_wid), 64'd0);
    check("rst_pc", 64'(sched_pc), 64'd0);
    check("rst_tmask", 64'(sched_tmask), 64'd0);
    check("rst_pending", 64'(pending_warps), 64'd0);
    check("rst_err", 64'(err_release), 64'd0);

    // All warps ready: 0,1,2,3 back to back, then idle with everything pending
    active_warps = 4'b1111;
    sched_ready  = 1'b1;
    fired.delete();
    repeat (6) tick();
    check("t1_count", 64'(fired.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      check("t1_order", 64'(i < fired.size() ? fired[i] : -1), 64'(i));
    check("t1_valid_low", 64'(sched_valid), 64'd0);
    check("t1_pending", 64'(pending_warps), 64'hF);

    // Release wid 2: reissued two cycles later, nothing in between
    release_valid = 1'b1;
    release_wid   = 2'd2;
    fired.delete();
    tick();
    release_valid = 1'b0;
    check("t2_gap", 64'(sched_valid), 64'd0);
    tick();
    check("t2_valid", 64'(sched_valid), 64'd1);
    check("t2_wid", 64'(sched_wid), 64'd2);
    tick();
    check("t2_fired", 64'(fired.size() == 1 && fired[0] == 2), 64'd1);

    // Backpressure hold while the shown warp is deactivated
    do_reset();
    new_pcs();
    active_warps = 4'b0010;
    sched_ready  = 1'b0;
    tick();
    hold_pc = warp_pcs[1*PCB +: PCB];
    active_warps = 4'b0000;
    new_pcs();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", 64'(sched_valid), 64'd1);
      check("t3_hold_wid", 64'(sched_wid), 64'd1);
      check("t3_hold_pc", 64'(sched_pc), 64'(hold_pc));
      check("t3_hold_tmask", 64'(sched_tmask), 64'hF);
    end
    fired.delete();
    sched_ready = 1'b1;
    tick();
    check("t3_fire", 64'(fired.size() == 1 && fired[0] == 1), 64'd1);

    // Stalled and empty-mask warps never issue
    do_reset();
    stalled_warps = 4'b0101;
    thread_masks  = 16'h0FFF;
    active_warps  = 4'b1111;
    fired.delete();
    repeat (6) tick();
    release_valid = 1'b1;
    release_wid   = 2'd1;
    tick();
    release_valid = 1'b0;
    repeat (5) tick();
    check("t4_count", 64'(fired.size()), 64'd2);
    foreach (fired[i]) check("t4_only_w1", 64'(fired[i]), 64'd1);

    // Release of a non-pending warp sets a sticky error
    do_reset();
    active_warps  = '0;
    stalled_warps = '0;
    thread_masks  = '1;
    release_valid = 1'b1;
    release_wid   = 2'd3;
    tick();
    release_valid = 1'b0;
    check("t5_err", 64'(err_release), 64'd1);
    repeat (3) tick();
    check("t5_err_sticky", 64'(err_release), 64'd1);
    check("t5_pending", 64'(pending_warps), 64'd0);
    do_reset();
    check("t5_err_cleared", 64'(err_release), 64'd0);

    // Reset with an in-flight request
    active_warps = 4'b0011;
    sched_ready  = 1'b1;
    tick();
    tick();
    sched_ready = 1'b0;
    check("t6_valid", 64'(sched_valid), 64'd1);
    check("t6_pending", 64'(pending_warps), 64'h3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_valid", 64'(sched_valid), 64'd0);
    check("t6_rst_pending", 64'(pending_warps), 64'd0);
    sched_ready = 1'b1;
    fired.delete();
    repeat (3) tick();
    check("t6_first", 64'(fired.size() > 0 ? fired[0] : -1), 64'd0);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 800; c++) begin
      active_warps  = 4'($urandom);
      stalled_warps = 4'($urandom) & 4'($urandom);
      for (int w = 0; w < NW; w++)
        thread_masks[w*NT +: NT] = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      new_pcs();
      sched_ready   = ($urandom_range(0, 9) < 7);
      release_valid = 1'b0;
      if (m_pending != '0 && $urandom_range(0, 2) == 0) begin
        int pick;
        pick = $urandom_range(0, NW - 1);
        while (!m_pending[pick]) pick = (pick + 1) % NW;
        release_valid = 1'b1;
        release_wid   = 2'(pick);
      end else if ($urandom_range(0, 59) == 0) begin
        release_valid = 1'b1;
        release_wid   = 2'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset         = 1'b0;
    release_valid = 1'b0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_issue_select.md
Name: warp_issue_select

Overview:
- Consumes the scheduler's per-warp state (active_warps, stalled_warps, thread_masks, warp_pcs).
- Each cycle, picks one eligible warp round-robin and presents {wid, PC, tmask} to fetch through a registered valid/ready handshake.
- Tracks one outstanding request per warp, so a warp is not reissued until fetch returns a release for it.

Parameters:
- NUM_WARPS, 4, number of warps; must be ≥2.
- NUM_THREADS, 4, threads per warp.
- PC_BITS, 30, PC width; the value matches the package.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- active_warps  in  NUM_WARPS  warp is active.
- stalled_warps  in  NUM_WARPS  warp is stalled by branch/gpgpu.
- thread_masks  in  NUM_WARPS*NUM_THREADS  per-warp thread mask.
- warp_pcs  in  NUM_WARPS*PC_BITS  per-warp PC.
- sched_valid  out  1  request valid.
- sched_ready  in  1  fetch accepts.
- sched_wid  out  NW_WIDTH  selected warp.
- sched_pc  out  PC_BITS  PC of the selected warp.
- sched_tmask  out  NUM_THREADS  thread mask of the selected warp.
- release_valid  in  1  fetch finished a request.
- release_wid  in  NW_WIDTH  warp being released.
- pending_warps  out  NUM_WARPS  outstanding-request bitmap.
- err_release  out  1  sticky: a release arrived for a non-pending warp.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - sched_valid=0; sched_wid, sched_pc and sched_tmask=0.
  - pending_warps=0; err_release=0.
  - rr_ptr=NUM_WARPS-1, so warp 0 wins first.
- Eligibility (combinational, from registered pending): eligible[w] = active[w] & ~stalled[w] & ~pending[w] & (thread_masks[w]!=0).
- Pick: the first eligible index scanning rr_ptr+1, rr_ptr+2, … modulo NUM_WARPS. The wrap is a plain modulo on the NW_WIDTH index.
- Load condition: load = (~sched_valid | sched_ready) & (eligible!=0).
- On load:
  - Register the winner's wid, pc and tmask into the output regs.
  - sched_valid=1.
  - pending[wid] set.
  - rr_ptr=wid.
- If not loading and sched_ready is high, sched_valid goes to 0.
- Latency: eligibility in cycle N → sched_valid in N+1.
- Full throughput: a back-to-back handshake with a different warp every cycle is allowed.
- Hold while valid & ~ready:
  - Outputs stay stable even if that warp is deactivated or stalled afterwards. No retraction.
  - rr_ptr is frozen.
- Release:
  - release_valid clears pending[release_wid] at the clock edge.
  - The warp becomes eligible in the following cycle, so it is reselected no earlier than 2 cycles after the release.
- Same-cycle load and release of the same warp cannot happen, because the pending warp is not eligible. No priority rule is needed.
- Release of a different warp in the same cycle as a load: both updates apply.
- Release of a non-pending wid: ignored, and err_release sets (stays set until reset).
- Release of a wid ≥ NUM_WARPS: treated as a non-pending wid (ignored, err_release sets).
- Reset mid-operation: any in-flight output is dropped and pending is cleared. Fetch must also be reset.

Optional Feature:
- Macro: WARP_ISSUE_PERF_EN.
- When defined, adds three 32-bit outputs, all cleared by reset and saturating at all-ones:
  - perf_issued: counts fires (valid & ready).
  - perf_idle: counts cycles with ~sched_valid & active_warps!=0.
  - perf_backpressure: counts cycles with sched_valid & ~sched_ready.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- VX_tb_common_pkg holds PC_BITS, NW_WIDTH, and a packed struct sched_req_t {wid, pc, tmask}. The output register uses this struct.
- One sub-module, warp_rr_pick:
  - Parameterised N.
  - Inputs: request vector, pointer.
  - Outputs: grant index, any-valid.
  - Combinational, also reusable for other round-robin points.
- Pending bitmap, output register and perf counters stay in the top module.

Test Plan:
- After reset, active=4'b1111, stalled=0, tmasks=4'hF, ready=1, no releases → issues wids 0,1,2,3 on consecutive cycles, then sched_valid=0. pending=4'b1111.
- Release wid 2 in cycle N with active=4'b1111, ready=1 → wid 2 issued at N+2. No other warp issues in between.
- valid=1 with wid 1, ready=0 for 5 cycles while active[1] drops → sched_wid/pc/tmask unchanged for all 5 cycles, and wid 1 fires when ready=1.
- stalled=4'b0101, thread_masks[3]=0, active=4'b1111 → only wid 1 issues. Release wid 1 → wid 1 reissues. Wids 0, 2, 3 never issue.
- release_valid with wid 3 while pending=0 → err_release=1 and stays 1. pending unchanged. Next reset clears it.
- Assert reset while valid=1 and pending=4'b0011 → next cycle sched_valid=0, pending=0. First issue after reset is wid 0.
